// File: rtl/router_pkt_fifo_pkg.sv
// Shared constants, types and helpers for the router output FIFO slice.
package router_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_LEN_LSB = 2;
  localparam int DEF_LEN_W   = 6;

  // Why the FIFO is being cleared this cycle; visible in the top for debug.
  typedef enum logic [1:0] {
    FLUSH_NONE    = 2'd0,
    FLUSH_SOFT    = 2'd1,
    FLUSH_TIMEOUT = 2'd2
  } flush_cause_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Header length field, extracted on a wide bus so any parameterisation fits.
  function automatic logic [63:0] hdr_len(input logic [63:0] hdr, input int lsb, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return (hdr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Channel-side bundle of the packet FIFO: write port, read port and status.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int LW = clog2(DEPTH) + 1;

  // Handshake: write_enb/read_enb are single-cycle strobes with no ready wait;
  // a write is taken on an edge only when !full and a read only when !empty.
  // Refused writes raise overflow, refused reads leave data_valid low.
  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              pkt_last;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              timeout;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, data_valid, pkt_last, full, empty, almost_full, level, overflow, timeout
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, data_valid, pkt_last, full, empty, almost_full, level, overflow, timeout
  );

endinterface

// File: rtl/router_stall_timer.sv
// Counts cycles where data sits unread and requests a flush after TIMEOUT of them.
module router_stall_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic soft_reset,
  input  logic empty,
  input  logic read_enb,
  output logic flush_req,
  output logic timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // TIMEOUT of zero keeps the counter parked at zero, so no request ever fires.
  assign flush_req = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = flush_req && !soft_reset;
    if (soft_reset || flush_req || empty || read_enb) begin
      cnt_d = '0;
    end else if (cnt_q < CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router channel: tagged storage, packet-end
// tracking from the header length field, occupancy flags and a stall flush.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LEN_LSB  = DEF_LEN_LSB,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int TIMEOUT  = 30
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               soft_reset,
  router_pkt_fifo_if.slave   bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = LEN_W + 1;

  logic [DATA_W:0]   mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              pkt_last_q, pkt_last_d;
  logic              overflow_q, overflow_d;
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;

  logic [PW-1:0]     level;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              flush_req;
  logic              timeout_pulse;
  flush_cause_e      flush_cause;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W:0]   rd_entry;

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign almost_full = (32'(level) >= AF_LEVEL);

  router_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .empty      (empty),
    .read_enb   (bus.read_enb),
    .flush_req  (flush_req),
    .timeout    (timeout_pulse)
  );

  always_comb begin
    flush_cause = FLUSH_NONE;
    if (soft_reset) begin
      flush_cause = FLUSH_SOFT;
    end else if (flush_req) begin
      flush_cause = FLUSH_TIMEOUT;
    end
  end

  assign wr_acc   = bus.write_enb && !full  && (flush_cause == FLUSH_NONE);
  assign rd_acc   = bus.read_enb  && !empty && (flush_cause == FLUSH_NONE);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pkt_last_d   = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;
    overflow_d   = 1'b0;
    if (flush_cause != FLUSH_NONE) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      pkt_cnt_d  = '0;
    end else begin
      overflow_d = bus.write_enb && full;
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        data_out_d   = rd_entry[DATA_W-1:0];
        data_valid_d = 1'b1;
        // A header reloads len+1 so the parity byte is the one that hits zero.
        if (rd_entry[DATA_W]) begin
          pkt_cnt_d = CW'(hdr_len(64'(rd_entry[DATA_W-1:0]), LEN_LSB, LEN_W) + 64'd1);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d  = pkt_cnt_q - CW'(1);
          pkt_last_d = (pkt_cnt_q == CW'(1));
        end
      end
    end
  end

  // Storage is deliberately not reset; a flush only rewinds the pointers.
  always_ff @(posedge clock) begin
    if (resetn && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_last_q   <= 1'b0;
      pkt_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pkt_last_q   <= pkt_last_d;
      pkt_cnt_q    <= pkt_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.pkt_last    = pkt_last_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = almost_full;
  assign bus.level       = level;
  assign bus.overflow    = overflow_q;
  assign bus.timeout     = timeout_pulse;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: one instance with TIMEOUT=30, one with TIMEOUT=0.
module tb_router_pkt_fifo;

  logic clock;
  logic resetn;
  logic soft_reset;

  int n_chk;
  int n_fail;

  logic [7:0] exp_q[$];

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();
  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) bus0 ();

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .LEN_LSB(2), .LEN_W(6), .AF_LEVEL(14), .TIMEOUT(30)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .LEN_LSB(2), .LEN_W(6), .AF_LEVEL(14), .TIMEOUT(0)) dut0 (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus0)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic w, input logic l, input logic [7:0] d, input logic r);
    bus.write_enb = w;
    bus.lfd_state = l;
    bus.data_in   = d;
    bus.read_enb  = r;
  endtask

  task automatic drive0(input logic w, input logic [7:0] d, input logic r);
    bus0.write_enb = w;
    bus0.lfd_state = 1'b0;
    bus0.data_in   = d;
    bus0.read_enb  = r;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic w, input logic l, input logic [7:0] d, input logic r);
    drive(w, l, d, r);
    step();
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pkt_a [5];
    logic [7:0] pkt_b [4];
    logic [7:0] wv;
    logic [7:0] ev;

    n_chk  = 0;
    n_fail = 0;
    pkt_a  = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
    pkt_b  = '{8'h08, 8'hD1, 8'hD2, 8'hD3};

    // reset then idle
    resetn     = 1'b0;
    soft_reset = 1'b0;
    drive(0, 0, 8'h00, 0);
    drive0(0, 8'h00, 0);
    step();
    step();
    chk("rst_empty",       32'(bus.empty),       32'd1);
    chk("rst_full",        32'(bus.full),        32'd0);
    chk("rst_level",       32'(bus.level),       32'd0);
    chk("rst_data_out",    32'(bus.data_out),    32'h0);
    chk("rst_data_valid",  32'(bus.data_valid),  32'd0);
    chk("rst_pkt_last",    32'(bus.pkt_last),    32'd0);
    chk("rst_almost_full", 32'(bus.almost_full), 32'd0);
    chk("rst_overflow",    32'(bus.overflow),    32'd0);
    chk("rst_timeout",     32'(bus.timeout),     32'd0);
    resetn = 1'b1;
    step();

    // packet pass-through: header 0C (len 3), 3 payload, parity
    for (int i = 0; i < 5; i++) begin
      cyc(1, (i == 0), pkt_a[i], 0);
      if (i == 0) chk("pt_empty_drop", 32'(bus.empty), 32'd0);
    end
    chk("pt_level5", 32'(bus.level), 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'h00, 1);
      chk($sformatf("pt_data%0d", i),  32'(bus.data_out),   32'(pkt_a[i]));
      chk($sformatf("pt_valid%0d", i), 32'(bus.data_valid), 32'd1);
      chk($sformatf("pt_last%0d", i),  32'(bus.pkt_last),   32'((i == 4) ? 1 : 0));
    end
    cyc(0, 0, 8'h00, 0);
    chk("pt_level0",    32'(bus.level),      32'd0);
    chk("pt_empty",     32'(bus.empty),      32'd1);
    chk("pt_valid_off", 32'(bus.data_valid), 32'd0);

    // fill, almost_full, full, overflow
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'(8'h80 + 8'(i)), 0);
      if (i == 12) chk("fill_af_13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("fill_af_14", 32'(bus.almost_full), 32'd1);
      if (i == 14) chk("fill_full_15", 32'(bus.full), 32'd0);
    end
    chk("fill_full_16",  32'(bus.full),     32'd1);
    chk("fill_level_16", 32'(bus.level),    32'd16);
    chk("fill_ovf_none", 32'(bus.overflow), 32'd0);
    cyc(1, 0, 8'hF0, 0);
    chk("fill_ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("fill_level_kept", 32'(bus.level),   32'd16);
    // read+write while full: read proceeds, write blocked
    cyc(1, 0, 8'h99, 1);
    chk("full_rw_data",  32'(bus.data_out), 32'h80);
    chk("full_rw_ovf",   32'(bus.overflow), 32'd1);
    chk("full_rw_level", 32'(bus.level),    32'd15);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 8'h00, 1);
      chk($sformatf("drain_data%0d", i), 32'(bus.data_out), 32'(8'h80 + 8'(i)));
      chk($sformatf("drain_last%0d", i), 32'(bus.pkt_last), 32'd0);
      if (i == 1) chk("drain_ovf_clear", 32'(bus.overflow), 32'd0);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    cyc(0, 0, 8'h00, 1);
    chk("empty_rd_valid", 32'(bus.data_valid), 32'd0);
    chk("empty_rd_hold",  32'(bus.data_out),   32'h8F);
    // read+write while empty: write proceeds, read ignored
    cyc(1, 0, 8'h77, 1);
    chk("empty_rw_valid", 32'(bus.data_valid), 32'd0);
    chk("empty_rw_level", 32'(bus.level),      32'd1);
    cyc(0, 0, 8'h00, 1);
    chk("empty_rw_data",  32'(bus.data_out),   32'h77);
    chk("empty_rw_empty", 32'(bus.empty),      32'd1);

    // sustained read+write at level 8 across pointer wraps
    wv = 8'h20;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, wv, 0);
      exp_q.push_back(wv);
      wv = wv + 8'd1;
    end
    chk("wrap_level_pre", 32'(bus.level), 32'd8);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, wv, 1);
      exp_q.push_back(wv);
      wv = wv + 8'd1;
      ev = exp_q.pop_front();
      chk($sformatf("wrap_data%0d", i),  32'(bus.data_out), 32'(ev));
      chk($sformatf("wrap_level%0d", i), 32'(bus.level),    32'd8);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 8'h00, 1);
      ev = exp_q.pop_front();
      chk($sformatf("wrap_tail%0d", i), 32'(bus.data_out), 32'(ev));
    end
    chk("wrap_empty", 32'(bus.empty), 32'd1);

    // stall timeout on dut, none on dut0
    for (int i = 0; i < 3; i++) begin
      drive0(1, 8'(8'hA1 + 8'(i)), 0);
      cyc(1, 0, 8'(8'hA1 + 8'(i)), 0);
    end
    drive0(0, 8'h00, 0);
    for (int k = 3; k <= 30; k++) cyc(0, 0, 8'h00, 0);
    chk("to_not_yet",   32'(bus.timeout), 32'd0);
    chk("to_level_pre", 32'(bus.level),   32'd3);
    cyc(0, 0, 8'h00, 0);
    chk("to_pulse",     32'(bus.timeout),  32'd1);
    chk("to_empty",     32'(bus.empty),    32'd1);
    chk("to_level",     32'(bus.level),    32'd0);
    chk("to_data_out",  32'(bus.data_out), 32'h0);
    chk("to0_no_pulse", 32'(bus0.timeout), 32'd0);
    chk("to0_level",    32'(bus0.level),   32'd3);
    cyc(0, 0, 8'h00, 0);
    chk("to_pulse_end", 32'(bus.timeout),  32'd0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 8'h00, 0);
    chk("to0_still_level", 32'(bus0.level), 32'd3);
    chk("to0_still_none",  32'(bus0.timeout), 32'd0);

    // soft reset mid-packet (header 14 = len 5)
    cyc(1, 1, 8'h14, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hB1 + 8'(i)), 0);
    cyc(1, 0, 8'hC6, 0);
    cyc(0, 0, 8'h00, 1);
    chk("sr_hdr_data", 32'(bus.data_out), 32'h14);
    cyc(0, 0, 8'h00, 1);
    chk("sr_pay_data", 32'(bus.data_out), 32'hB1);
    chk("sr_pay_last", 32'(bus.pkt_last), 32'd0);
    soft_reset = 1'b1;
    cyc(1, 0, 8'hEE, 0);
    soft_reset = 1'b0;
    chk("sr_empty",    32'(bus.empty),      32'd1);
    chk("sr_level",    32'(bus.level),      32'd0);
    chk("sr_data_out", 32'(bus.data_out),   32'h0);
    chk("sr_valid",    32'(bus.data_valid), 32'd0);
    cyc(0, 0, 8'h00, 0);
    chk("sr_discard",  32'(bus.level),      32'd0);
    for (int i = 0; i < 4; i++) cyc(1, (i == 0), pkt_b[i], 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 8'h00, 1);
      chk($sformatf("sr_nx_data%0d", i), 32'(bus.data_out), 32'(pkt_b[i]));
      chk($sformatf("sr_nx_last%0d", i), 32'(bus.pkt_last), 32'((i == 3) ? 1 : 0));
    end

    // len = 0: header then parity
    cyc(1, 1, 8'h00, 0);
    cyc(1, 0, 8'h5C, 0);
    cyc(0, 0, 8'h00, 1);
    chk("len0_hdr_last", 32'(bus.pkt_last), 32'd0);
    cyc(0, 0, 8'h00, 1);
    chk("len0_par_data", 32'(bus.data_out), 32'h5C);
    chk("len0_par_last", 32'(bus.pkt_last), 32'd1);
    cyc(0, 0, 8'h00, 0);
    chk("len0_last_end", 32'(bus.pkt_last), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware output FIFO for the 1x3 router: one instance per output channel between the router FSM/register stage and the channel read port. It stores each byte with a start-of-packet tag, tracks remaining bytes of the packet being read from the header length field, and reports occupancy and almost-full. It adds an internal stall timeout that flushes a channel nobody reads.

## Interface
- DATA_W, 8, data byte width.
- DEPTH, 16, entries; power of two, ≥4.
- LEN_LSB, 2, LSB position of the length field in the header byte.
- LEN_W, 6, length field width; LEN_LSB+LEN_W ≤ DATA_W.
- AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.
- TIMEOUT, 30, consecutive stalled cycles before an automatic flush; 0 disables the timeout.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  reset; synchronous, active-low.
- soft_reset  in  1  synchronous flush request from the synchroniser.
- write_enb  in  1  write strobe.
- lfd_state  in  1  current write is a header byte; aligned with write_enb and data_in.
- data_in  in  DATA_W  write data.
- read_enb  in  1  read strobe.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out was loaded this cycle.
- pkt_last  out  1  with data_valid: byte is the packet's final (parity) byte.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy ≥ AF_LEVEL.
- level  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  one-cycle pulse: write attempted while full, data dropped.
- timeout  out  1  one-cycle pulse: auto-flush happened.

## Operation
- Storage: DEPTH × (DATA_W+1). The tag bit is lfd_state sampled in the same cycle as the data. There is no one-cycle lfd delay.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - full: index bits equal and wrap bits differ.
  - empty: pointers equal.
- Write accepted when write_enb && !full. If write_enb && full, the data is dropped and overflow pulses.
- Read accepted when read_enb && !empty. On a read, data_out is loaded, the read pointer increments, and data_valid is 1 the next cycle. A read while empty is ignored: data_valid=0 and data_out holds. data_out is never driven Z.
- Packet counter (LEN_W+1 bits):
  - Reading a tagged entry loads len+1, where len is the header's length field.
  - Reading an untagged entry decrements the counter, saturating at 0.
  - pkt_last asserts when an untagged read decrements the counter from 1 to 0.
  - A header with len=0 yields header then parity; pkt_last is on the parity byte.
- Simultaneous accepted read and write: level is unchanged. When full, the read proceeds and the write is blocked (overflow pulses). When empty, the write proceeds and the read is ignored.
- Stall timer: counts cycles with !empty && !read_enb, and clears on any accepted read or when empty. When it reaches TIMEOUT, the flush acts as a soft_reset.
- Flush (soft_reset or timeout):
  - Cleared: pointers, level, packet counter, stall timer.
  - data_out → 0, data_valid → 0.
  - Memory contents are not cleared.
  - A write in the same cycle is discarded.
- Priority: resetn > soft_reset > timeout flush > read/write.

## Timing
- Reset values: data_out=0, data_valid=0, pkt_last=0, full=0, empty=1, almost_full=0 (AF_LEVEL≥1), level=0, overflow=0, timeout=0.
- Write-to-read latency: a byte written at edge N makes empty drop after N. The earliest read is at edge N+1, with data_out/data_valid valid after N+1.
- Flags full, empty, almost_full are decoded combinationally from registered pointers/level. They update the cycle after the causing edge.
- Timeout: after TIMEOUT consecutive stalled cycles, the flush takes effect at the next edge. The timeout output pulses in the following cycle, together with empty=1.
- Wrap-around: pointers wrap modulo 2·DEPTH without glitching full/empty.

## Structure
- Package router_pkg: DATA_W, LEN_LSB, LEN_W defaults; header length-extract function; clog2 helper.
- Sub-module router_stall_timer: the stall counter, TIMEOUT compare, and timeout pulse register.
- Memory: inferred array, no reset on the array.

## Test plan
- Reset then idle: after resetn low 2 cycles → empty=1, level=0, data_out=0, all pulses 0.
- Packet pass-through: write header 8'h0C (len 3), payload 11, 22, 33, parity 5A; then read 5 → data_out C,11,22,33,5A in order; pkt_last only on 5A; level returns to 0.
- Fill and overflow, DEPTH=16: write 17 bytes → full=1 after the 16th; 17th gives an overflow pulse; almost_full asserts at level 14; read all 16 → original order, 17th absent.
- Simultaneous read/write across wrap: sustain write+read for 40 cycles at level 8 → level stays 8, data order intact across 2+ pointer wraps.
- Timeout: write 3 bytes, hold read_enb=0 for 30 cycles → timeout pulse in cycle 31, empty=1, level=0; with TIMEOUT=0 no flush occurs.
- Soft reset mid-packet: after reading header and 1 payload of len-5 packet, assert soft_reset with write_enb=1 → empty=1, written byte discarded; next packet's pkt_last is correct.
